// File: rtl/kan_pkg.sv
// Shared types and per-layer defaults for the KAN trainer's piecewise-linear
// coefficient units (forward and backward paths).
package kan_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_MULT  = 2'd2,
    S_WRITE = 2'd3
  } kan_upd_state_t;

  typedef logic signed [31:0] kan_coef_t;

  localparam int KAN_N_POINTS      = 14;
  localparam int KAN_N_DELTA_SHIFT = 17;

  // Words per function in each parity bank (the even bank holds the extra point when odd).
  function automatic int kan_bank_words(input int n_points);
    return (n_points + 1) / 2;
  endfunction

endpackage

// File: rtl/kan_coef_bank.sv
// Single-clock coefficient RAM: one write port, one read port, registered read
// output that holds its value while i_re is low.
module kan_coef_bank
  import kan_pkg::*;
#(
  parameter  int DEPTH = 4081,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  kan_coef_t       i_wdata,
  input  logic            i_re,
  input  logic [AW-1:0]   i_raddr,
  output kan_coef_t       o_rdata
);

  kan_coef_t r_mem [DEPTH];
  kan_coef_t r_q;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/kan_pl_update.sv
// Per-layer piecewise-linear coefficient store with load, endpoint-pair read and
// residual update of the segment endpoints hit during the forward pass.
module kan_pl_update
  import kan_pkg::*;
#(
  parameter  int N_FUNCS       = 583,
  parameter  int N_POINTS      = KAN_N_POINTS,
  parameter  int N_DELTA_SHIFT = KAN_N_DELTA_SHIFT,
  localparam int FW            = $clog2(N_FUNCS),
  localparam int PW            = $clog2(N_POINTS)
) (
  input  logic                CLK100MHZ,
  input  logic                RESET,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [FW-1:0]       ld_func,
  input  logic [PW-1:0]       ld_point,
  input  logic signed [31:0]  ld_data,
  input  logic                up_valid,
  output logic                up_ready,
  input  logic [FW-1:0]       up_func,
  input  logic [PW-1:0]       up_index,
  input  logic [31:0]         up_offset,
  input  logic signed [63:0]  up_residual,
  output logic                up_done,
  output logic                up_err,
  input  logic                rd_valid,
  output logic                rd_ready,
  input  logic [FW-1:0]       rd_func,
  input  logic [PW-1:0]       rd_index,
  output logic                rd_out_valid,
  output logic                rd_err,
  output logic signed [31:0]  rd_f0,
  output logic signed [31:0]  rd_f1,
  output logic                busy
);

  localparam int HALF  = kan_bank_words(N_POINTS);
  localparam int DEPTH = N_FUNCS * HALF;
  localparam int AW    = $clog2(DEPTH);

  function automatic logic [AW-1:0] f_addr(input logic [FW-1:0] func, input logic [PW-1:0] word);
    return AW'(32'(func) * 32'(HALF) + 32'(word));
  endfunction

  // Even bank word holding the even endpoint of segment idx (f[idx] or f[idx+1]).
  function automatic logic [PW-1:0] f_hi(input logic [PW-1:0] idx);
    return (idx + PW'(1)) >> 1;
  endfunction

  kan_upd_state_t     r_state;
  logic               r_up_done, r_up_err, r_rd_valid, r_rd_err, r_rd_par;
  logic [FW-1:0]      r_func;
  logic [PW-1:0]      r_idx;
  logic [31:0]        r_off;
  logic signed [63:0] r_res;
  kan_coef_t          r_a, r_b, r_tmp;

  logic               w_idle, w_ld_acc, w_up_acc, w_rd_acc;
  logic               w_ld_ok, w_up_bad, w_rd_bad;
  logic               w_we_e, w_we_o, w_re;
  logic [AW-1:0]      w_waddr_e, w_waddr_o, w_raddr_e, w_raddr_o;
  kan_coef_t          w_wdata_e, w_wdata_o, w_q_e, w_q_o;
  logic signed [63:0] w_prod;
  kan_coef_t          w_tmp, w_new_a, w_new_b;

  assign w_idle   = (r_state == S_IDLE);
  assign ld_ready = w_idle;
  assign up_ready = w_idle & ~ld_valid;
  assign rd_ready = w_idle & ~ld_valid & ~up_valid;

  assign w_ld_acc = ld_valid & ld_ready & ~RESET;
  assign w_up_acc = up_valid & up_ready & ~RESET;
  assign w_rd_acc = rd_valid & rd_ready & ~RESET;

  assign w_ld_ok  = (int'(ld_func) < N_FUNCS) && (int'(ld_point) < N_POINTS);
  assign w_up_bad = (int'(up_index) > N_POINTS - 2) || (int'(up_func) >= N_FUNCS);
  assign w_rd_bad = (int'(rd_index) > N_POINTS - 2) || (int'(rd_func) >= N_FUNCS);

  assign w_prod  = r_res * $signed({32'd0, r_off});
  assign w_tmp   = 32'(w_prod >>> N_DELTA_SHIFT);
  assign w_new_b = r_b + r_tmp;
  assign w_new_a = r_a + ($signed(r_res[31:0]) - r_tmp);

  always_comb begin
    w_we_e    = 1'b0;
    w_we_o    = 1'b0;
    w_waddr_e = '0;
    w_waddr_o = '0;
    w_wdata_e = '0;
    w_wdata_o = '0;
    if (r_state == S_WRITE && !RESET) begin
      w_we_e    = 1'b1;
      w_we_o    = 1'b1;
      w_waddr_e = f_addr(r_func, f_hi(r_idx));
      w_waddr_o = f_addr(r_func, r_idx >> 1);
      w_wdata_e = r_idx[0] ? w_new_b : w_new_a;
      w_wdata_o = r_idx[0] ? w_new_a : w_new_b;
    end else if (w_ld_acc && w_ld_ok) begin
      w_we_e    = ~ld_point[0];
      w_we_o    = ld_point[0];
      w_waddr_e = f_addr(ld_func, ld_point >> 1);
      w_waddr_o = f_addr(ld_func, ld_point >> 1);
      w_wdata_e = ld_data;
      w_wdata_o = ld_data;
    end
  end

  always_comb begin
    w_re      = 1'b0;
    w_raddr_e = '0;
    w_raddr_o = '0;
    if (r_state == S_READ) begin
      w_re      = 1'b1;
      w_raddr_e = f_addr(r_func, f_hi(r_idx));
      w_raddr_o = f_addr(r_func, r_idx >> 1);
    end else if (w_rd_acc && !w_rd_bad) begin
      w_re      = 1'b1;
      w_raddr_e = f_addr(rd_func, f_hi(rd_index));
      w_raddr_o = f_addr(rd_func, rd_index >> 1);
    end
  end

  kan_coef_bank #(.DEPTH(DEPTH)) u_bank_e (
    .clk(CLK100MHZ), .i_we(w_we_e), .i_waddr(w_waddr_e), .i_wdata(w_wdata_e),
    .i_re(w_re), .i_raddr(w_raddr_e), .o_rdata(w_q_e)
  );

  kan_coef_bank #(.DEPTH(DEPTH)) u_bank_o (
    .clk(CLK100MHZ), .i_we(w_we_o), .i_waddr(w_waddr_o), .i_wdata(w_wdata_o),
    .i_re(w_re), .i_raddr(w_raddr_o), .o_rdata(w_q_o)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_up_done  <= 1'b0;
      r_up_err   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_rd_par   <= 1'b0;
    end else begin
      r_up_done  <= (r_state == S_WRITE);
      r_up_err   <= w_up_acc & w_up_bad;
      r_rd_valid <= w_rd_acc;
      r_rd_err   <= w_rd_acc & w_rd_bad;
      if (w_rd_acc) r_rd_par <= rd_index[0];
      case (r_state)
        S_IDLE:  if (w_up_acc && !w_up_bad) r_state <= S_READ;
        S_READ:  r_state <= S_MULT;
        S_MULT:  r_state <= S_WRITE;
        S_WRITE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The bank's registered output acts as the READ-stage register; a/b are
  // re-latched in MULT alongside tmp so the bank read port is free again.
  always_ff @(posedge CLK100MHZ) begin
    if (w_up_acc) begin
      r_func <= up_func;
      r_idx  <= up_index;
      r_off  <= up_offset;
      r_res  <= up_residual;
    end
    if (r_state == S_MULT) begin
      r_a   <= r_idx[0] ? w_q_o : w_q_e;
      r_b   <= r_idx[0] ? w_q_e : w_q_o;
      r_tmp <= w_tmp;
    end
  end

  assign up_done      = r_up_done;
  assign up_err       = r_up_err;
  assign rd_out_valid = r_rd_valid;
  assign rd_err       = r_rd_err;
  assign busy         = ~w_idle;
  assign rd_f0        = (r_rd_valid && !r_rd_err) ? (r_rd_par ? w_q_o : w_q_e) : '0;
  assign rd_f1        = (r_rd_valid && !r_rd_err) ? (r_rd_par ? w_q_e : w_q_o) : '0;

endmodule

// File: tb/tb_kan_pl_update.sv
// Randomized and directed bench for kan_pl_update against a flat-array
// coefficient model updated with plain 64-bit integer arithmetic.
module tb_kan_pl_update;

  localparam int NF = 583;
  localparam int NP = 14;
  localparam int DS = 17;

  logic               clk = 1'b0;
  logic               rst;
  logic               ld_valid, ld_ready;
  logic [9:0]         ld_func;
  logic [3:0]         ld_point;
  logic signed [31:0] ld_data;
  logic               up_valid, up_ready;
  logic [9:0]         up_func;
  logic [3:0]         up_index;
  logic [31:0]        up_offset;
  logic signed [63:0] up_residual;
  logic               up_done, up_err;
  logic               rd_valid, rd_ready;
  logic [9:0]         rd_func;
  logic [3:0]         rd_index;
  logic               rd_out_valid, rd_err;
  logic signed [31:0] rd_f0, rd_f1;
  logic               busy;

  int n_total = 0;
  int n_bad   = 0;
  int model [NF][NP];
  int fl [6] = '{0, 1, 5, 100, 581, 582};

  kan_pl_update #(.N_FUNCS(NF), .N_POINTS(NP), .N_DELTA_SHIFT(DS)) dut (
    .CLK100MHZ(clk), .RESET(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_func(ld_func), .ld_point(ld_point), .ld_data(ld_data),
    .up_valid(up_valid), .up_ready(up_ready), .up_func(up_func), .up_index(up_index),
    .up_offset(up_offset), .up_residual(up_residual), .up_done(up_done), .up_err(up_err),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_func(rd_func), .rd_index(rd_index),
    .rd_out_valid(rd_out_valid), .rd_err(rd_err), .rd_f0(rd_f0), .rd_f1(rd_f1), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int f, input int p, input int d);
    ld_valid = 1'b1; ld_func = 10'(f); ld_point = 4'(p); ld_data = d;
    tick();
    ld_valid = 1'b0;
    if (f < NF && p < NP) model[f][p] = d;
  endtask

  task automatic do_read(input int f, input int idx);
    bit bad;
    bad = (idx > NP - 2) || (f >= NF);
    rd_valid = 1'b1; rd_func = 10'(f); rd_index = 4'(idx);
    tick();
    rd_valid = 1'b0;
    check("rd_out_valid", rd_out_valid, 1);
    check("rd_err", rd_err, bad ? 1 : 0);
    if (bad) begin
      check("rd_f0_bad", rd_f0, 0);
      check("rd_f1_bad", rd_f1, 0);
    end else begin
      check("rd_f0", rd_f0, model[f][idx]);
      check("rd_f1", rd_f1, model[f][idx+1]);
    end
  endtask

  // Returns in the cycle after the final state so a next request lands in cycle 4 (or 1 on error).
  task automatic do_update(input int f, input int idx, input longint off, input longint res, input bit rst3);
    bit bad;
    longint prod;
    int tmp;
    bad = (idx > NP - 2) || (f >= NF);
    up_valid = 1'b1; up_func = 10'(f); up_index = 4'(idx);
    up_offset = 32'(off); up_residual = res;
    tick();
    up_valid = 1'b0;
    if (bad) begin
      check("up_err_c1", up_err, 1);
      check("up_done_err", up_done, 0);
      check("busy_err", busy, 0);
      check("up_ready_c1", up_ready, 1);
      return;
    end
    check("up_err_ok", up_err, 0);
    for (int c = 1; c <= 3; c++) begin
      check("busy_c", busy, 1);
      check("up_done_early", up_done, 0);
      if (c == 3 && rst3) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    if (rst3) begin
      check("busy_after_rst", busy, 0);
      check("up_done_rst", up_done, 0);
    end else begin
      check("up_done_c4", up_done, 1);
      check("busy_c4", busy, 0);
      prod = res * off;
      tmp  = int'(prod >>> DS);
      model[f][idx+1] = model[f][idx+1] + tmp;
      model[f][idx]   = model[f][idx] + (int'(res) - tmp);
    end
  endtask

  initial begin
    int k, f, idx;
    longint res;

    rst = 1'b1;
    ld_valid = 0; ld_func = '0; ld_point = '0; ld_data = '0;
    up_valid = 0; up_func = '0; up_index = '0; up_offset = '0; up_residual = '0;
    rd_valid = 0; rd_func = '0; rd_index = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_up_done", up_done, 0);
    check("rst_up_err", up_err, 0);
    check("rst_rd_out_valid", rd_out_valid, 0);
    check("rst_rd_err", rd_err, 0);
    check("rst_rd_f0", rd_f0, 0);
    check("rst_rd_f1", rd_f1, 0);
    check("rst_busy", busy, 0);
    check("rst_ld_ready", ld_ready, 1);
    check("rst_up_ready", up_ready, 1);
    check("rst_rd_ready", rd_ready, 1);

    foreach (fl[i])
      for (int p = 0; p < NP; p++) do_load(fl[i], p, int'($urandom));

    // Positive update
    do_load(5, 3, 1000);
    do_load(5, 4, 3000);
    do_update(5, 3, 65536, 400, 1'b0);
    do_read(5, 3);
    check("pos_f0", rd_f0, 1200);
    check("pos_f1", rd_f1, 3200);

    // Negative residual exercises the arithmetic shift
    do_update(5, 3, 1, -7, 1'b0);
    do_read(5, 3);
    check("neg_f0", rd_f0, 1194);
    check("neg_f1", rd_f1, 3199);

    // Bad index and bad function, each followed at once by another update
    do_update(5, 13, 100, 12345, 1'b0);
    do_update(5, 2, 70000, 9999, 1'b0);
    do_update(583, 0, 100, 12345, 1'b0);
    do_update(0, 12, 131071, -123456789, 1'b0);
    for (int i = 0; i <= NP - 2; i++) do_read(5, i);

    // Priority: load wins, update follows, read held off
    ld_valid = 1'b1; ld_func = 10'd100; ld_point = 4'd2; ld_data = 32'sd777;
    up_valid = 1'b1; up_func = 10'd100; up_index = 4'd5; up_offset = 32'd5000; up_residual = 64'sd3000;
    rd_valid = 1'b1; rd_func = 10'd100; rd_index = 4'd0;
    #1;
    check("prio_ld_ready", ld_ready, 1);
    check("prio_up_ready", up_ready, 0);
    check("prio_rd_ready", rd_ready, 0);
    tick();
    model[100][2] = 777;
    ld_valid = 1'b0;
    #1;
    check("prio_up_ready2", up_ready, 1);
    check("prio_rd_ready2", rd_ready, 0);
    rd_valid = 1'b0;
    do_update(100, 5, 5000, 3000, 1'b0);
    do_read(100, 2);
    do_read(100, 5);

    // Reset during WRITE aborts the update
    do_load(5, 3, 1000);
    do_load(5, 4, 3000);
    do_update(5, 3, 65536, 400, 1'b1);
    do_read(5, 3);
    check("rstw_f0", rd_f0, 1000);
    check("rstw_f1", rd_f1, 3000);

    // Back-to-back read stream
    rd_valid = 1'b1; rd_func = 10'd0; rd_index = 4'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stream_valid", rd_out_valid, 1);
      check("stream_f0", rd_f0, model[0][i]);
      check("stream_f1", rd_f1, model[0][i+1]);
      rd_index = 4'(i + 1);
    end
    rd_valid = 1'b0;
    tick();
    check("stream_end", rd_out_valid, 0);

    // Load followed by an immediate read of the same point
    do_load(1, 7, -42);
    do_read(1, 7);
    do_read(1, 6);
    do_read(5, 13);
    do_read(600, 0);

    for (int n = 0; n < 300; n++) begin
      k   = int'($urandom_range(0, 9));
      f   = fl[$urandom_range(0, 5)];
      idx = int'($urandom_range(0, 15));
      if (k < 3) begin
        do_load(f, int'($urandom_range(0, NP - 1)), int'($urandom));
      end else if (k < 6) begin
        case ($urandom_range(0, 2))
          0:       res = longint'($urandom_range(0, 2000)) - 1000;
          1:       res = longint'(int'($urandom));
          default: res = {$urandom, $urandom};
        endcase
        if ($urandom_range(0, 15) == 0) f = NF + int'($urandom_range(0, 440));
        do_update(f, idx, longint'($urandom_range(0, (1 << DS) - 1)), res, 1'b0);
      end else begin
        if ($urandom_range(0, 15) == 0) f = NF + int'($urandom_range(0, 440));
        do_read(f, idx);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/kan_pl_update.md
# kan_pl_update

Synthesizable backward-path unit for the 4-layer integer KAN trainer. It owns one layer's piecewise-linear coefficient store and applies residual updates to the two endpoints of the segment hit during the forward pass. It also serves endpoint-pair reads to the forward and difference logic, and accepts initial coefficient loads. One instance sits per layer, fed by the delta/backprop stage.

## Interface
- N_FUNCS, 583: functions in the layer (inputs × blocks).
- N_POINTS, 14: points per function; must be ≥ 2.
- N_DELTA_SHIFT, 17: offset fraction width.
- FW = $clog2(N_FUNCS), PW = $clog2(N_POINTS): derived, not overridable.

Ports:
- CLK100MHZ  in  1  sole clock.
- RESET  in  1  synchronous, active-high.
- ld_valid / ld_ready  in/out  1  coefficient load handshake.
- ld_func, ld_point, ld_data  in  FW / PW / 32 signed  load target and value.
- up_valid / up_ready  in/out  1  update handshake.
- up_func, up_index  in  FW / PW  function and segment index.
- up_offset  in  32  position in segment, 0..2^N_DELTA_SHIFT-1.
- up_residual  in  64 signed  scaled residual (already alpha-shifted).
- up_done, up_err  out  1  one-cycle completion / rejection pulses.
- rd_valid / rd_ready  in/out  1  read handshake.
- rd_func, rd_index  in  FW / PW  segment to read.
- rd_out_valid, rd_err  out  1  read result strobe / bad-index flag.
- rd_f0, rd_f1  out  32 signed  f[index], f[index+1].
- busy  out  1  high when the FSM is not IDLE.

## Operation
- Storage is split into two banks by point parity:
  - even points in bank E, odd points in bank O;
  - bank address = func·ceil(N_POINTS/2) + (point>>1);
  - f[i] and f[i+1] always sit in different banks.
- FSM states: IDLE, READ, MULT, WRITE.
- Arbitration in IDLE, priority load > update > read:
  - ld_ready = IDLE;
  - up_ready = IDLE & !ld_valid;
  - rd_ready = IDLE & !ld_valid & !up_valid.
  - All three are combinational.
- Load: written to its bank on the accept edge; FSM stays IDLE.
- Update accept: latch all fields.
  - If up_index > N_POINTS-2 or up_func ≥ N_FUNCS: pulse up_err next cycle, no write, stay IDLE.
  - Otherwise go to READ.
- READ: register a = f[idx], b = f[idx+1].
- MULT: prod = up_residual × up_offset (64-bit signed); tmp = (prod >>> N_DELTA_SHIFT)[31:0].
- WRITE: both banks are written on the same edge:
  - f[idx+1] ← b + tmp;
  - f[idx] ← a + (up_residual[31:0] − tmp).
  - Then go to IDLE.
- Arithmetic is 32-bit two's-complement wraparound with no saturation. Shifts are arithmetic.
- Read: f[index] and f[index+1] are returned one cycle after accept.
  - Bad index or function: rd_err = 1, rd_f0 = rd_f1 = 0.
- Reset:
  - FSM goes to IDLE and all pulses/outputs clear.
  - An in-flight update is aborted. If RESET is high in the WRITE cycle, neither bank is written.
  - Coefficients are not cleared by reset.

## Timing
- Reset values: up_done = up_err = rd_out_valid = rd_err = 0, rd_f0 = rd_f1 = 0, busy = 0. Ready outputs follow the IDLE equations.
- Update accepted at edge 0:
  - READ in cycle 1, MULT in cycle 2, WRITE in cycle 3;
  - memory updated at edge 4;
  - up_done high in cycle 4, together with IDLE.
  - A new request can be accepted in cycle 4, giving 1 update per 4 cycles.
- up_err is high in cycle 1; another update can be accepted in cycle 1.
- Read accepted at edge 0: rd_out_valid, rd_f0 and rd_f1 are valid in cycle 1. Back-to-back reads give 1 per cycle.
- Read after update: a read accepted in cycle 4 or later returns the new values (no stale data).
- Load then read of the same point on the next cycle returns the loaded value.

## Structure
- Package kan_pkg holds:
  - the state enum kan_upd_state_t;
  - the coefficient type kan_coef_t (logic signed [31:0]);
  - per-layer defaults for N_POINTS and N_DELTA_SHIFT, shared with the forward unit.
- Sub-module kan_coef_bank: single-clock RAM with 1 read and 1 write, registered read, instantiated twice (E/O). All arithmetic and the FSM stay in the top level.

## Test plan
- Parameters for all cases: N_DELTA_SHIFT = 17, N_POINTS = 14.
- Positive update:
  - Stimulus: load f[5][3] = 1000, f[5][4] = 3000; update func 5, idx 3, offset 65536, residual 400.
  - Required: up_done 4 cycles after accept; readback f0 = 1200, f1 = 3200.
- Negative residual:
  - Stimulus: same segment, residual −7, offset 1.
  - Required: tmp = −1; f[4] decreases by 1 and f[3] decreases by 6 (checks the arithmetic shift).
- Bad index:
  - Stimulus: update idx 13.
  - Required: up_err pulse in cycle 1, no up_done, all coefficients unchanged, next request accepted in cycle 1.
- Priority:
  - Stimulus: ld_valid and up_valid high in the same cycle.
  - Required: load taken and up_ready low that cycle; update accepted the next cycle; rd_ready low while up_valid is high.
- Reset in WRITE:
  - Stimulus: assert RESET in cycle 3 of the positive update.
  - Required: readback 1000/3000, busy = 0, no up_done.
- Read stream:
  - Stimulus: 4 back-to-back reads of idx 0..3.
  - Required: rd_out_valid continuous for 4 cycles with correct pairs.
